// File: rtl/sqg_pattern_tx.sv
// Serial pattern transmitter: shifts an accepted word out MSB-first, repeated pat_rep+1 times with GAP idle bits between.
// Latency: first bit one cycle after the transfer edge; done pulses the cycle after the last bit.
// Backpressure: pat_ready only in IDLE (not during rst); optional abort input under SQG_ABORT_EN.
module sqg_pattern_tx #(
  parameter int   WIDTH    = 4,
  parameter int   CNT_W    = 8,
  parameter int   GAP      = 1,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pat_valid,
  output logic                       pat_ready,
  input  logic [WIDTH-1:0]           pat_data,
  input  logic [$clog2(WIDTH+1)-1:0] pat_len,
  input  logic [CNT_W-1:0]           pat_rep,
  output logic                       out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done
`ifdef SQG_ABORT_EN
  ,
  input  logic                       abort
`endif
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    last_q, last_d;   // index of the first (MSB) bit sent, len-1
  logic [IW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LW-1:0]    eff_len;
  logic             abort_req;

`ifdef SQG_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign pat_ready = (state_q == ST_IDLE) && !rst;

  always_comb begin
    eff_len = pat_len;
    if (pat_len == '0 || pat_len > LW'(WIDTH)) eff_len = LW'(WIDTH);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pat_valid && pat_ready) begin
          data_d  = pat_data;
          last_d  = IW'(eff_len - LW'(1));
          bit_d   = IW'(eff_len - LW'(1));
          rep_d   = pat_rep;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_q != '0) begin
          bit_d = bit_q - IW'(1);
        end else if (rep_q != '0) begin
          rep_d = rep_q - CNT_W'(1);
          if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GW'(GAP - 1);
          end else begin
            bit_d = last_q;
          end
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_SHIFT;
          bit_d   = last_q;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // abort beats completion, including on the last-bit cycle
    if (abort_req && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
    out_valid_d = (state_d == ST_SHIFT);
    out_d       = out_valid_d ? data_d[bit_d] : IDLE_BIT;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      last_q      <= '0;
      bit_q       <= '0;
      rep_q       <= '0;
      gap_q       <= '0;
      out_q       <= IDLE_BIT;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      last_q      <= last_d;
      bit_q       <= bit_d;
      rep_q       <= rep_d;
      gap_q       <= gap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
